// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// default widths and requester index constants.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } arb_state_t;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for two requesters: a sole requester wins outright,
// a tie goes to the requester named by ptr.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic winner,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      winner = ptr;
    end else if (req1) begin
      winner = REQ1;
    end else begin
      winner = REQ0;
    end
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Two-requester arbiter in front of an external single-port memory with
// one-cycle registered read data. MEM_ARB_FIXED_PRIO_EN: requester 0 wins ties.
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wr_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic winner;
  logic any_req;
  logic other_req;

  mem_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  // State register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q  <= ST_IDLE;
      owner_q  <= REQ0;
      ptr_q    <= REQ0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Only the non-owner's request matters during ACC; the owner's own
  // request is re-arbitrated once the FSM is back in IDLE.
  assign other_req = (owner_q == REQ1) ? req0 : req1;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ACC;
          owner_d = winner;
        end
      end
      ST_ACC: begin
        ptr_d = ~owner_q;
        if (other_req) begin
          owner_d = ~owner_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MEM_ARB_FIXED_PRIO_EN
    ptr_d = REQ0;
`endif
  end

  // Output logic
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_wr_rd = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rvalid_d  = '0;
    if (state_q == ST_ACC) begin
      if (owner_q == REQ1) begin
        gnt1      = 1'b1;
        mem_wr_rd = wr1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
        rvalid_d[REQ1] = ~wr1;
      end else begin
        gnt0      = 1'b1;
        mem_wr_rd = wr0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        rvalid_d[REQ0] = ~wr0;
      end
    end
  end

  // Read data passes straight from memory in the valid cycle, then is held.
  assign rvalid0  = rvalid_q[REQ0];
  assign rvalid1  = rvalid_q[REQ1];
  assign rdata0   = rvalid_q[REQ0] ? mem_rdata : rdata0_q;
  assign rdata1   = rvalid_q[REQ1] ? mem_rdata : rdata1_q;
  assign rdata0_d = rdata0;
  assign rdata1_d = rdata1;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a behavioural registered-read memory.
module tb_mem_arbiter_2p;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset_p;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_wr_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  mem_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_p(reset_p),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    for (int unsigned i = 0; i < (1<<AW); i++) mem[i] = '0;
    tick(); tick();
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk1("rst_rvalid1", rvalid1, 1'b0);
    chkw("rst_rdata0", 16'(rdata0), 16'h0);
    chkw("rst_mem_addr", 16'(mem_addr), 16'h0);
    chk1("rst_mem_wr", mem_wr_rd, 1'b0);
    reset_p = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    req0 = 1; wr0 = 1; addr0 = 10'h005; wdata0 = 8'hA5;
    #1;
    chk1("wr_idle_gnt0", gnt0, 1'b0);
    tick();
    chk1("wr_gnt0", gnt0, 1'b1);
    chk1("wr_mem_wr", mem_wr_rd, 1'b1);
    chkw("wr_mem_addr", 16'(mem_addr), 16'h005);
    chkw("wr_mem_wdata", 16'(mem_wdata), 16'h0A5);
    req0 = 0;
    tick();
    chk1("wr_gnt0_pulse", gnt0, 1'b0);
    chk1("wr_no_rvalid0", rvalid0, 1'b0);
    req1 = 1; wr1 = 0; addr1 = 10'h005;
    tick();
    chk1("rd_gnt1", gnt1, 1'b1);
    chk1("rd_mem_wr", mem_wr_rd, 1'b0);
    req1 = 0;
    tick();
    chk1("rd_rvalid1", rvalid1, 1'b1);
    chk1("rd_rvalid0_low", rvalid0, 1'b0);
    chkw("rd_rdata1", 16'(rdata1), 16'h0A5);
    tick();
    chk1("rd_rvalid1_pulse", rvalid1, 1'b0);
    chkw("rd_rdata1_hold", 16'(rdata1), 16'h0A5);
  endtask

  task automatic test_wr_then_rd_other();
    req0 = 1; wr0 = 1; addr0 = 10'h010; wdata0 = 8'h33;
    req1 = 1; wr1 = 0; addr1 = 10'h010;
    tick();
    chk1("raw_gnt0", gnt0, 1'b1);
    chk1("raw_gnt1_low", gnt1, 1'b0);
    req0 = 0;
    tick();
    chk1("raw_gnt1", gnt1, 1'b1);
    chkw("raw_mem_addr", 16'(mem_addr), 16'h010);
    req1 = 0;
    tick();
    chk1("raw_rvalid1", rvalid1, 1'b1);
    chkw("raw_rdata1", 16'(rdata1), 16'h033);
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_owner;
    logic prev_read_owner;
    req0 = 1; wr0 = 0; addr0 = 10'h005;
    req1 = 1; wr1 = 0; addr1 = 10'h010;
    exp_owner = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("b2b_gnt0", gnt0, ~exp_owner);
      chk1("b2b_gnt1", gnt1, exp_owner);
      chk1("b2b_rvalid_excl", rvalid0 & rvalid1, 1'b0);
      if (i > 0) begin
        prev_read_owner = ~exp_owner;
        chk1("b2b_rvalid0", rvalid0, ~prev_read_owner);
        chk1("b2b_rvalid1", rvalid1, prev_read_owner);
        if (prev_read_owner) chkw("b2b_rdata1", 16'(rdata1), 16'h033);
        else chkw("b2b_rdata0", 16'(rdata0), 16'h0A5);
      end
      exp_owner = ~exp_owner;
    end
    req0 = 0; req1 = 0;
    tick();
    chk1("b2b_end_gnt", gnt0 | gnt1, 1'b0);
    chk1("b2b_last_rvalid1", rvalid1, 1'b1);
    tick();
  endtask

  task automatic test_tie_pointer();
    logic first;
    // Leave the pointer at 1 with a lone requester-0 access, then tie.
    req0 = 1; wr0 = 0; addr0 = 10'h005;
    tick();
    chk1("tie_pre_gnt0", gnt0, 1'b1);
    req0 = 0;
    tick(); tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    req0 = 1; req1 = 1;
    tick();
    chk1("tie_first_gnt0", gnt0, ~first);
    chk1("tie_first_gnt1", gnt1, first);
    if (first) req1 = 0; else req0 = 0;
    tick();
    chk1("tie_second_gnt0", gnt0, first);
    chk1("tie_second_gnt1", gnt1, ~first);
    req0 = 0; req1 = 0;
    tick(); tick();
  endtask

  task automatic test_addr_wrap();
    req0 = 1; wr0 = 1; addr0 = 10'h3FF; wdata0 = 8'h5A;
    tick();
    chkw("wrap_mem_addr", 16'(mem_addr), 16'h3FF);
    req0 = 0;
    tick();
    req0 = 1; wr0 = 0;
    tick();
    chk1("wrap_gnt0", gnt0, 1'b1);
    req0 = 0;
    tick();
    chk1("wrap_rvalid0", rvalid0, 1'b1);
    chkw("wrap_rdata0", 16'(rdata0), 16'h05A);
    tick();
    chk1("wrap_rvalid0_pulse", rvalid0, 1'b0);
  endtask

  task automatic test_reset_in_acc();
    req0 = 1; wr0 = 0; addr0 = 10'h005;
    tick();
    chk1("racc_gnt0", gnt0, 1'b1);
    reset_p = 1'b1;
    #1;
    chk1("racc_gnt0_reset", gnt0, 1'b0);
    chkw("racc_mem_addr_reset", 16'(mem_addr), 16'h0);
    req0 = 0;
    tick();
    reset_p = 1'b0;
    tick();
    chk1("racc_rvalid0", rvalid0, 1'b0);
    chk1("racc_rvalid1", rvalid1, 1'b0);
    chk1("racc_gnt", gnt0 | gnt1, 1'b0);
    chkw("racc_rdata0", 16'(rdata0), 16'h0);
    chkw("racc_mem_addr", 16'(mem_addr), 16'h0);
    chk1("racc_mem_wr", mem_wr_rd, 1'b0);
    tick();
    chk1("racc_rvalid0_late", rvalid0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wr_then_rd_other();
    test_back_to_back();
    test_tie_pointer();
    test_addr_wrap();
    test_reset_in_acc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
